multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Moore FSM sequencer for the multi-cycle MIPS-subset datapath (R-type, lw, sw, beq, addi, j).
//  Sits between the instruction register and the shared datapath. Drives every mux select and enable.
//  Sequences each instruction over 3-5 states and stalls on a ready handshake from the single shared memory.
//  Traps on an illegal opcode or a memory timeout, and parks in IDLE while the program is being loaded.
// PARAMETERS
//  OP_W         6   opcode width (instruction bits [31:26])
//  TIMEOUT      15  max wait cycles on mem_ready before trapping; legal range 1..255
//  SUPPORT_JUMP 1   1: opcode 000010 (j) is legal; 0: j traps as illegal
// PORTS
//  clk          in   1       clock
//  clr          in   1       reset, asynchronous, active-low
//  run          in   1       1: execute; 0: stop at the next instruction boundary
//  prog_write   in   1       program-load mode: finish the current instruction, then hold IDLE
//  opcode       in   OP_W    IR[31:26]
//  zero         in   1       ALU zero flag
//  mem_ready    in   1       memory has completed the requested read/write this cycle
//  pc_write     out  1       load PC
//  pc_src       out  2       00 ALU, 01 ALUOut (branch target), 10 jump target
//  i_or_d       out  1       memory address source: 0 PC, 1 ALUOut
//  mem_read     out  1       memory read request
//  mem_write    out  1       memory write request
//  ir_write     out  1       load IR
//  reg_dst      out  1       register write address: 1 rd, 0 rt
//  mem_to_reg   out  1       register write data: 1 MDR, 0 ALUOut
//  reg_write    out  1       register file write enable
//  alu_src_a    out  1       ALU A: 0 PC, 1 rs
//  alu_src_b    out  2       ALU B: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op       out  2       00 add, 01 sub, 10 funct-decoded
//  busy         out  1       state is not IDLE and not TRAP
//  illegal_op   out  1       sticky; set on entry to TRAP from DECODE
//  mem_timeout  out  1       sticky; set on entry to TRAP from a wait state
// BEHAVIOUR
//  - Reset (clr=0): state is IDLE immediately, asynchronously. Every output is 0, the wait counter is 0
//    and both sticky flags are cleared.
//  - IDLE -> FETCH when run=1 and prog_write=0. Otherwise stay in IDLE.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
//    Stays in FETCH until mem_ready=1. In that cycle only, ir_write=1 and pc_write=1 with pc_src=00, then -> DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode:
//    000000 EXEC_R; 100011 or 101011 MEM_ADDR; 000100 BRANCH; 001000 EXEC_I;
//    000010 JUMP if SUPPORT_JUMP=1; any other opcode -> TRAP.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_RD, sw -> MEM_WR.
//  - MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then -> MEM_WB.
//  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1.
//  - MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1.
//  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
//  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00, then -> I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero (combinational).
//  - JUMP: pc_write=1, pc_src=10.
//  - Last state of each instruction (MEM_WB, MEM_WR on completion, R_WB, I_WB, BRANCH, JUMP):
//    next state is FETCH if run=1 and prog_write=0, otherwise IDLE.
//  - Latency with zero-wait memory, in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//  - Wait counter (8 bits, saturating): cleared on entry to FETCH, MEM_RD and MEM_WR; increments each
//    cycle the state holds with mem_ready=0. The cycle after the count reaches TIMEOUT with mem_ready still 0:
//    -> TRAP, mem_timeout=1. If mem_ready=1 in the same cycle the count reaches TIMEOUT, the access completes normally.
//  - TRAP is absorbing: all strobes are 0 and busy=0. Only reset leaves TRAP.
//  - run or prog_write changing mid-instruction never aborts it: no partial register or memory write is possible.
//  - Every output except ir_write, pc_write and busy is a pure decode of the state register.
//    ir_write and pc_write additionally use mem_ready or zero as listed above.
// STRUCTURE
//  - Package mcu_pkg: state_t enum (IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB,
//    EXEC_I, I_WB, BRANCH, JUMP, TRAP), opcode localparams, and the alu_op, pc_src and alu_src_b encodings.
//  - Sub-module mem_wait_timer: clear, count and saturate logic with a TIMEOUT parameter; output expired.
//  - Top level: state register, next-state logic, output decode.
// TESTING
//  - Reset and IDLE: clr=0 with run=1 -> all outputs 0. Release clr with run=0 -> stays IDLE for 10 cycles, busy=0.
//  - Zero-wait sequences (mem_ready tied 1): lw (100011) -> FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, reg_write
//    on cycle 5. sw -> mem_write on cycle 4. R-type -> reg_dst=1 on cycle 4.
//  - beq: zero=1 -> pc_write=1, pc_src=01 in cycle 3. zero=0 -> pc_write=0. Both return to FETCH.
//  - Wait states: mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, lw takes 8 cycles total, no trap.
//  - Timeout (TIMEOUT=4): mem_ready held 0 in FETCH -> TRAP after 5 cycles, mem_timeout=1. run toggling has no effect.
//  - Illegal and mode: opcode 111111 -> TRAP, illegal_op=1. SUPPORT_JUMP=0 with j -> TRAP. prog_write=1
//    during EXEC_R -> R_WB completes, then IDLE.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
// Datapath select encodings match the mux wiring of the shared datapath.
package mcu_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    R_WB     = 4'd8,
    EXEC_I   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // States that stall on the shared memory's ready handshake.
  function automatic logic isWaitState(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating 8-bit wait-cycle counter; expired once the count has reached TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 8'd0;
    end else if (clear_i) begin
      count_q <= 8'd0;
    end else if (count_i && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired_o = (count_q >= LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multi-cycle MIPS-subset datapath: drives every select and
// enable, stalls on memory ready, traps on illegal opcodes and memory timeouts.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OP_W         = 6,
  parameter int TIMEOUT      = 15,
  parameter bit SUPPORT_JUMP = 1'b1
) (
  input  logic            clk_i,
  input  logic            clr_ni,
  input  logic            run_i,
  input  logic            prog_write_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic [1:0]      pc_src_o,
  output logic            i_or_d_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            ir_write_o,
  output logic            reg_dst_o,
  output logic            mem_to_reg_o,
  output logic            reg_write_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      alu_op_o,
  output logic            busy_o,
  output logic            illegal_op_o,
  output logic            mem_timeout_o
);

  state_t state_q, state_d;
  state_t nextInstr;
  logic   illegal_q, timeout_q;
  logic   timerClear, timerCount, timerExpired;

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP && state_q == DECODE) illegal_q <= 1'b1;
      if (state_d == TRAP && isWaitState(state_q)) timeout_q <= 1'b1;
    end
  end

  assign nextInstr = (run_i && !prog_write_i) ? FETCH : IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (run_i && !prog_write_i) state_d = FETCH;
      FETCH:    if (mem_ready_i) state_d = DECODE;
                else if (timerExpired) state_d = TRAP;
      DECODE: begin
        case (opcode_i)
          OP_W'(OP_RTYPE):        state_d = EXEC_R;
          OP_W'(OP_LW),
          OP_W'(OP_SW):           state_d = MEM_ADDR;
          OP_W'(OP_BEQ):          state_d = BRANCH;
          OP_W'(OP_ADDI):         state_d = EXEC_I;
          OP_W'(OP_J):            state_d = SUPPORT_JUMP ? JUMP : TRAP;
          default:                state_d = TRAP;
        endcase
      end
      MEM_ADDR: state_d = (opcode_i == OP_W'(OP_SW)) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready_i) state_d = MEM_WB;
                else if (timerExpired) state_d = TRAP;
      MEM_WR:   if (mem_ready_i) state_d = nextInstr;
                else if (timerExpired) state_d = TRAP;
      EXEC_R:   state_d = R_WB;
      EXEC_I:   state_d = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_d = nextInstr;
      TRAP:     state_d = TRAP;
      default:  state_d = TRAP;
    endcase
  end

  // Count restarts on entry to a wait state, so a held access gets the full budget.
  assign timerClear = (state_d != state_q) && isWaitState(state_d);
  assign timerCount = isWaitState(state_q) && !mem_ready_i;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (clr_ni),
    .clear_i  (timerClear),
    .count_i  (timerCount),
    .expired_o(timerExpired)
  );

  always_comb begin
    pc_write_o   = 1'b0;
    pc_src_o     = PC_SRC_ALU;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_RT;
    alu_op_o     = ALU_ADD;
    case (state_q)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE:   alu_src_b_o = SRCB_IMM_SH2;
      MEM_ADDR, EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      I_WB:     reg_write_o = 1'b1;
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = PC_SRC_ALUOUT;
        pc_write_o  = zero_i;
      end
      JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

  assign busy_o        = (state_q != IDLE) && (state_q != TRAP);
  assign illegal_op_o  = illegal_q;
  assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: expected output words per state are
// hand-derived; a second instance with SUPPORT_JUMP=0 covers the jump-disabled trap.
module tb_multicycle_control_unit;

  // Packed output word: {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
  // reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, busy}
  localparam logic [15:0] IDLE_V     = 16'h0000;
  localparam logic [15:0] FETCH_WAIT = 16'h0809;
  localparam logic [15:0] FETCH_RDY  = 16'h8A09;
  localparam logic [15:0] DECODE_V   = 16'h0019;
  localparam logic [15:0] MEMADDR_V  = 16'h0031;
  localparam logic [15:0] MEMRD_V    = 16'h1801;
  localparam logic [15:0] MEMWB_V    = 16'h00C1;
  localparam logic [15:0] MEMWR_V    = 16'h1401;
  localparam logic [15:0] EXECR_V    = 16'h0025;
  localparam logic [15:0] RWB_V      = 16'h0141;
  localparam logic [15:0] EXECI_V    = 16'h0031;
  localparam logic [15:0] IWB_V      = 16'h0041;
  localparam logic [15:0] BR_TAKEN   = 16'hA023;
  localparam logic [15:0] BR_NOT     = 16'h2023;
  localparam logic [15:0] JUMP_V     = 16'hC001;
  localparam logic [15:0] TRAP_V     = 16'h0000;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       clrN, run, progWrite, zero, memReady;
  logic [5:0] opcode;

  logic       pcWrite, iOrD, memRead, memWrite, irWrite, regDst, memToReg, regWrite;
  logic       aluSrcA, busy, illegalOp, memTimeout;
  logic [1:0] pcSrc, aluSrcB, aluOp;

  logic       njPcWrite, njIOrD, njMemRead, njMemWrite, njIrWrite, njRegDst, njMemToReg;
  logic       njRegWrite, njAluSrcA, njBusy, njIllegalOp, njMemTimeout;
  logic [1:0] njPcSrc, njAluSrcB, njAluOp;

  logic [15:0] obsMain, obsNoJump, flagsMain, flagsNoJump;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.OP_W(6), .TIMEOUT(4), .SUPPORT_JUMP(1'b1)) dut (
    .clk_i(clk), .clr_ni(clrN), .run_i(run), .prog_write_i(progWrite), .opcode_i(opcode),
    .zero_i(zero), .mem_ready_i(memReady), .pc_write_o(pcWrite), .pc_src_o(pcSrc),
    .i_or_d_o(iOrD), .mem_read_o(memRead), .mem_write_o(memWrite), .ir_write_o(irWrite),
    .reg_dst_o(regDst), .mem_to_reg_o(memToReg), .reg_write_o(regWrite),
    .alu_src_a_o(aluSrcA), .alu_src_b_o(aluSrcB), .alu_op_o(aluOp), .busy_o(busy),
    .illegal_op_o(illegalOp), .mem_timeout_o(memTimeout)
  );

  multicycle_control_unit #(.OP_W(6), .TIMEOUT(4), .SUPPORT_JUMP(1'b0)) dutNoJump (
    .clk_i(clk), .clr_ni(clrN), .run_i(run), .prog_write_i(progWrite), .opcode_i(opcode),
    .zero_i(zero), .mem_ready_i(memReady), .pc_write_o(njPcWrite), .pc_src_o(njPcSrc),
    .i_or_d_o(njIOrD), .mem_read_o(njMemRead), .mem_write_o(njMemWrite), .ir_write_o(njIrWrite),
    .reg_dst_o(njRegDst), .mem_to_reg_o(njMemToReg), .reg_write_o(njRegWrite),
    .alu_src_a_o(njAluSrcA), .alu_src_b_o(njAluSrcB), .alu_op_o(njAluOp), .busy_o(njBusy),
    .illegal_op_o(njIllegalOp), .mem_timeout_o(njMemTimeout)
  );

  assign obsMain = {pcWrite, pcSrc, iOrD, memRead, memWrite, irWrite, regDst, memToReg,
                    regWrite, aluSrcA, aluSrcB, aluOp, busy};
  assign obsNoJump = {njPcWrite, njPcSrc, njIOrD, njMemRead, njMemWrite, njIrWrite, njRegDst,
                      njMemToReg, njRegWrite, njAluSrcA, njAluSrcB, njAluOp, njBusy};
  assign flagsMain   = {14'b0, illegalOp, memTimeout};
  assign flagsNoJump = {14'b0, njIllegalOp, njMemTimeout};

  task automatic applyStimulus(input logic r, input logic pw, input logic [5:0] op,
                               input logic rdy, input logic z);
    run = r;
    progWrite = pw;
    opcode = op;
    memReady = rdy;
    zero = z;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges, checks the cleared state, releases on a falling edge.
  task automatic doReset(input string tag);
    clrN = 1'b0;
    #2;
    checkOutput({tag, "_outputs"}, obsMain, IDLE_V);
    checkOutput({tag, "_flags"}, flagsMain, 16'h0000);
    @(negedge clk);
    clrN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clrN = 1'b0;
    applyStimulus(1'b1, 1'b0, LW, 1'b1, 1'b0);
    #2;
    checkOutput("reset_outputs", obsMain, IDLE_V);
    checkOutput("reset_flags", flagsMain, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, LW, 1'b1, 1'b0);
    clrN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("idle_hold_%0d", i), obsMain, IDLE_V);
    end

    // lw, sw, R, addi, beq taken/not, j back to back with zero-wait memory
    applyStimulus(1'b1, 1'b0, LW, 1'b1, 1'b0);
    tick(); checkOutput("lw_c1_fetch", obsMain, FETCH_RDY);
    tick(); checkOutput("lw_c2_decode", obsMain, DECODE_V);
    tick(); checkOutput("lw_c3_memaddr", obsMain, MEMADDR_V);
    tick(); checkOutput("lw_c4_memrd", obsMain, MEMRD_V);
    tick(); checkOutput("lw_c5_memwb", obsMain, MEMWB_V);
    opcode = SW;
    tick(); checkOutput("sw_c1_fetch", obsMain, FETCH_RDY);
    tick(); tick();
    tick(); checkOutput("sw_c4_memwr", obsMain, MEMWR_V);
    opcode = RT;
    tick(); tick();
    tick(); checkOutput("r_c3_exec", obsMain, EXECR_V);
    tick(); checkOutput("r_c4_wb", obsMain, RWB_V);
    opcode = ADDI;
    tick(); tick();
    tick(); checkOutput("addi_c3_exec", obsMain, EXECI_V);
    tick(); checkOutput("addi_c4_wb", obsMain, IWB_V);
    applyStimulus(1'b1, 1'b0, BEQ, 1'b1, 1'b1);
    tick(); tick();
    tick(); checkOutput("beq_taken", obsMain, BR_TAKEN);
    zero = 1'b0;
    tick(); checkOutput("beq_back_to_fetch", obsMain, FETCH_RDY);
    tick();
    tick(); checkOutput("beq_not_taken", obsMain, BR_NOT);
    opcode = JMP;
    tick(); tick();
    tick(); checkOutput("j_c3_jump", obsMain, JUMP_V);

    // lw with three wait cycles in MEM_RD: 8 cycles total
    opcode = LW;
    tick(); tick(); tick();
    tick(); memReady = 1'b0; checkOutput("lwwait_c4_memrd", obsMain, MEMRD_V);
    tick(); checkOutput("lwwait_c5_memrd", obsMain, MEMRD_V);
    tick(); checkOutput("lwwait_c6_memrd", obsMain, MEMRD_V);
    tick(); memReady = 1'b1; checkOutput("lwwait_c7_memrd", obsMain, MEMRD_V);
    tick(); checkOutput("lwwait_c8_memwb", obsMain, MEMWB_V);
    checkOutput("lwwait_no_trap_flags", flagsMain, 16'h0000);

    // Ready arriving exactly when the count reaches the limit completes the fetch
    applyStimulus(1'b1, 1'b0, RT, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput($sformatf("limit_fetch_wait_%0d", i), obsMain, FETCH_WAIT);
    end
    tick(); memReady = 1'b1; #1;
    checkOutput("limit_fetch_completes", obsMain, FETCH_RDY);
    tick(); checkOutput("limit_no_trap_decode", obsMain, DECODE_V);
    tick(); tick(); memReady = 1'b0;

    // Fetch timeout with run toggling: five FETCH cycles then TRAP
    tick(); checkOutput("to_fetch_c1", obsMain, FETCH_WAIT);
    for (int i = 2; i <= 5; i++) begin
      run = ~run;
      tick();
      checkOutput($sformatf("to_fetch_c%0d", i), obsMain, FETCH_WAIT);
    end
    run = 1'b0;
    tick(); checkOutput("to_trap_outputs", obsMain, TRAP_V);
    checkOutput("to_trap_flags", flagsMain, 16'h0001);
    applyStimulus(1'b1, 1'b0, LW, 1'b1, 1'b0);
    tick(); tick();
    tick(); checkOutput("trap_absorbing", obsMain, TRAP_V);

    // Illegal opcode traps from DECODE; reset clears both sticky flags
    applyStimulus(1'b1, 1'b0, BAD, 1'b1, 1'b0);
    doReset("rst_after_timeout");
    tick(); checkOutput("ill_fetch", obsMain, FETCH_RDY);
    tick(); checkOutput("ill_decode", obsMain, DECODE_V);
    tick(); checkOutput("ill_trap_outputs", obsMain, TRAP_V);
    checkOutput("ill_trap_flags", flagsMain, 16'h0002);

    // j with and without jump support
    opcode = JMP;
    doReset("rst_before_j");
    tick(); tick();
    tick();
    checkOutput("j_supported", obsMain, JUMP_V);
    checkOutput("j_unsupported_trap", obsNoJump, TRAP_V);
    checkOutput("j_unsupported_flags", flagsNoJump, 16'h0002);

    // prog_write raised in EXEC_R: R_WB still completes, then IDLE
    opcode = RT;
    tick(); checkOutput("pw_fetch", obsMain, FETCH_RDY);
    tick();
    tick(); progWrite = 1'b1; checkOutput("pw_exec_r", obsMain, EXECR_V);
    tick(); checkOutput("pw_r_wb_completes", obsMain, RWB_V);
    tick(); checkOutput("pw_idle", obsMain, IDLE_V);
    tick(); checkOutput("pw_idle_hold", obsMain, IDLE_V);
    progWrite = 1'b0;
    tick(); checkOutput("pw_resume_fetch", obsMain, FETCH_RDY);

    // Asynchronous reset mid-instruction
    tick(); checkOutput("async_pre_decode", obsMain, DECODE_V);
    #2 clrN = 1'b0;
    #1 checkOutput("async_reset_outputs", obsMain, IDLE_V);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
